// File: rtl/fx_pkg.sv
// Shared types for the two-master fx bus arbiter: FSM state, slot op and slot contents.
package fx_pkg;

    localparam int FX_AW = 22;
    localparam int FX_DW = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        WAIT,
        RET
    } fx_arb_st_t;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } fx_op_t;

    // Slot storage is sized by the package widths; the arbiter ports cast into it.
    typedef struct packed {
        fx_op_t                 op;
        logic [FX_AW-1:0]       addr;
        logic [FX_DW-1:0]       data;
        logic                   vld;
    } fx_slot_t;

endpackage

// File: rtl/fx_arb_slot.sv
// One-deep request holding slot for a single master: capture, busy, overflow and
// the write-over-read rule. Cleared by the arbiter FSM when the slot is granted.
module fx_arb_slot
    import fx_pkg::*;
#(
    parameter int AW = FX_AW,
    parameter int DW = FX_DW
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          i_wr,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_data,
    input  logic          i_rd,
    input  logic [AW-1:0] i_raddr,
    input  logic          i_clr,
    output fx_slot_t      o_slot,
    output logic          o_busy,
    output logic          o_ovf
);

    fx_slot_t r_slot;
    logic     r_ovf;
    logic     w_req;

    assign w_req = i_wr | i_rd;

    // Busy is the registered valid bit, so a request in the release cycle is still dropped.
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_slot <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_ovf <= (w_req && r_slot.vld) || (i_wr && i_rd);
            if (r_slot.vld) begin
                if (i_clr) begin
                    r_slot.vld <= 1'b0;
                end
            end else if (w_req) begin
                r_slot.op   <= i_wr ? OP_WR : OP_RD;
                r_slot.addr <= FX_AW'(i_wr ? i_waddr : i_raddr);
                r_slot.data <= FX_DW'(i_data);
                r_slot.vld  <= 1'b1;
            end
        end
    end

    assign o_slot = r_slot;
    assign o_busy = r_slot.vld;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/fx_arb.sv
// Two-master fx bus arbiter: serialises master slots onto one fx bus and routes read data back.
// Define FX_ARB_RR_EN for round-robin arbitration; default is fixed priority m0 over m1.
module fx_arb
    import fx_pkg::*;
#(
    parameter int AW     = FX_AW,
    parameter int DW     = FX_DW,
    parameter int RD_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_waddr,
    input  logic [DW-1:0] m0_data,
    input  logic          m0_rd,
    input  logic [AW-1:0] m0_raddr,
    output logic [DW-1:0] m0_q,
    output logic          m0_qvld,
    output logic          m0_busy,
    output logic          m0_ovf,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_waddr,
    input  logic [DW-1:0] m1_data,
    input  logic          m1_rd,
    input  logic [AW-1:0] m1_raddr,
    output logic [DW-1:0] m1_q,
    output logic          m1_qvld,
    output logic          m1_busy,
    output logic          m1_ovf,
    output logic          fx_wr,
    output logic [AW-1:0] fx_waddr,
    output logic [DW-1:0] fx_data,
    output logic          fx_rd,
    output logic [AW-1:0] fx_raddr,
    input  logic [DW-1:0] fx_q
);

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    fx_arb_st_t    r_state;
    fx_arb_st_t    w_next;
    fx_slot_t      w_slot0;
    fx_slot_t      w_slot1;
    fx_slot_t      w_gslot;
    logic          w_sel;
    logic          w_grant;
    logic          r_owner;
    logic [2:0]    r_cnt;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic [AW-1:0] r_raddr;
    logic [DW-1:0] r_q0;
    logic [DW-1:0] r_q1;

    fx_arb_slot #(.AW(AW), .DW(DW)) u_slot0 (
        .clk_sys (clk_sys),
        .rst     (rst),
        .i_wr    (m0_wr),
        .i_waddr (m0_waddr),
        .i_data  (m0_data),
        .i_rd    (m0_rd),
        .i_raddr (m0_raddr),
        .i_clr   (w_grant && !w_sel),
        .o_slot  (w_slot0),
        .o_busy  (m0_busy),
        .o_ovf   (m0_ovf)
    );

    fx_arb_slot #(.AW(AW), .DW(DW)) u_slot1 (
        .clk_sys (clk_sys),
        .rst     (rst),
        .i_wr    (m1_wr),
        .i_waddr (m1_waddr),
        .i_data  (m1_data),
        .i_rd    (m1_rd),
        .i_raddr (m1_raddr),
        .i_clr   (w_grant && w_sel),
        .o_slot  (w_slot1),
        .o_busy  (m1_busy),
        .o_ovf   (m1_ovf)
    );

`ifdef FX_ARB_RR_EN
    logic r_last;

    // On contention grant the master that was not served last; otherwise whoever is valid.
    assign w_sel = (w_slot0.vld && w_slot1.vld) ? ~r_last : ~w_slot0.vld;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_sel;
        end
    end
`else
    assign w_sel = ~w_slot0.vld;
`endif

    assign w_grant = (r_state == IDLE) && (w_slot0.vld || w_slot1.vld);
    assign w_gslot = w_sel ? w_slot1 : w_slot0;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: the default assignment before the case keeps this block free of inferred latches.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next = (w_gslot.op == OP_WR) ? WR : RD;
                end
            end
            WR:      w_next = IDLE;
            RD:      w_next = WAIT;
            WAIT:    w_next = (r_cnt == 3'd0) ? RET : WAIT;
            RET:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        fx_wr   = 1'b0;
        fx_rd   = 1'b0;
        m0_qvld = 1'b0;
        m1_qvld = 1'b0;
        case (r_state)
            WR:      fx_wr = 1'b1;
            RD:      fx_rd = 1'b1;
            RET: begin
                m0_qvld = ~r_owner;
                m1_qvld = r_owner;
            end
            default: ;
        endcase
    end

    // Address/data registers only move on a grant of their own op, so they hold between strobes.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_cnt   <= 3'd0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_raddr <= '0;
            r_q0    <= '0;
            r_q1    <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_sel;
                if (w_gslot.op == OP_WR) begin
                    r_waddr <= AW'(w_gslot.addr);
                    r_wdata <= DW'(w_gslot.data);
                end else begin
                    r_raddr <= AW'(w_gslot.addr);
                end
            end
            if (r_state == RD) begin
                r_cnt <= LAT_LOAD;
            end else if (r_state == WAIT && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (r_state == WAIT && r_cnt == 3'd0) begin
                if (r_owner) begin
                    r_q1 <= fx_q;
                end else begin
                    r_q0 <= fx_q;
                end
            end
        end
    end

    assign fx_waddr = r_waddr;
    assign fx_data  = r_wdata;
    assign fx_raddr = r_raddr;
    assign m0_q     = r_q0;
    assign m1_q     = r_q1;

endmodule

// File: tb/tb_fx_arb.sv
// Scoreboard bench for fx_arb: directed stimulus pushes expected bus/return events,
// a negedge monitor pops and compares them. A second instance runs with RD_LAT=4.
`timescale 1ns/1ps
module tb_fx_arb;

    localparam int AW = 22;
    localparam int DW = 8;

    localparam int K_M0_OVF   = 0;
    localparam int K_M1_OVF   = 1;
    localparam int K_FX_WR    = 2;
    localparam int K_FX_RD    = 3;
    localparam int K_M0_QV    = 4;
    localparam int K_M1_QV    = 5;
    localparam int K_D4_RD    = 6;
    localparam int K_D4_QV    = 7;
    localparam int K_D4_OTHER = 8;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } ev_t;

    logic          clk_sys = 1'b0;
    logic          rst = 1'b1;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    ev_t           sb[$];
    int            exp_last = 1;

    logic          m0_wr = 1'b0, m0_rd = 1'b0, m1_wr = 1'b0, m1_rd = 1'b0;
    logic [AW-1:0] m0_waddr = '0, m0_raddr = '0, m1_waddr = '0, m1_raddr = '0;
    logic [DW-1:0] m0_data = '0, m1_data = '0;
    logic [DW-1:0] m0_q, m1_q, fx_data, fx_q;
    logic          m0_qvld, m0_busy, m0_ovf, m1_qvld, m1_busy, m1_ovf, fx_wr, fx_rd;
    logic [AW-1:0] fx_waddr, fx_raddr;

    logic          d4_m0_rd = 1'b0;
    logic [AW-1:0] d4_m0_raddr = '0;
    logic          d4_zero = 1'b0;
    logic [AW-1:0] d4_zaddr = '0;
    logic [DW-1:0] d4_zdata = '0;
    logic [DW-1:0] d4_m0_q, d4_m1_q, d4_fx_data, d4_fx_q;
    logic          d4_m0_qvld, d4_m0_busy, d4_m0_ovf, d4_m1_qvld, d4_m1_busy, d4_m1_ovf;
    logic          d4_fx_wr, d4_fx_rd;
    logic [AW-1:0] d4_fx_waddr, d4_fx_raddr;

    fx_arb #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut (
        .clk_sys(clk_sys), .rst(rst),
        .m0_wr(m0_wr), .m0_waddr(m0_waddr), .m0_data(m0_data), .m0_rd(m0_rd), .m0_raddr(m0_raddr),
        .m0_q(m0_q), .m0_qvld(m0_qvld), .m0_busy(m0_busy), .m0_ovf(m0_ovf),
        .m1_wr(m1_wr), .m1_waddr(m1_waddr), .m1_data(m1_data), .m1_rd(m1_rd), .m1_raddr(m1_raddr),
        .m1_q(m1_q), .m1_qvld(m1_qvld), .m1_busy(m1_busy), .m1_ovf(m1_ovf),
        .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
        .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q)
    );

    fx_arb #(.AW(AW), .DW(DW), .RD_LAT(4)) u_dut4 (
        .clk_sys(clk_sys), .rst(rst),
        .m0_wr(d4_zero), .m0_waddr(d4_zaddr), .m0_data(d4_zdata), .m0_rd(d4_m0_rd), .m0_raddr(d4_m0_raddr),
        .m0_q(d4_m0_q), .m0_qvld(d4_m0_qvld), .m0_busy(d4_m0_busy), .m0_ovf(d4_m0_ovf),
        .m1_wr(d4_zero), .m1_waddr(d4_zaddr), .m1_data(d4_zdata), .m1_rd(d4_zero), .m1_raddr(d4_zaddr),
        .m1_q(d4_m1_q), .m1_qvld(d4_m1_qvld), .m1_busy(d4_m1_busy), .m1_ovf(d4_m1_ovf),
        .fx_wr(d4_fx_wr), .fx_waddr(d4_fx_waddr), .fx_data(d4_fx_data),
        .fx_rd(d4_fx_rd), .fx_raddr(d4_fx_raddr), .fx_q(d4_fx_q)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // fx slave models: read data = addr[7:0] ^ 0x1C, valid exactly RD_LAT cycles after fx_rd, else 0xEE.
    always @(posedge clk_sys) fx_q <= fx_rd ? (fx_raddr[7:0] ^ 8'h1C) : 8'hEE;

    logic [7:0] p_d [4];
    logic [3:0] p_v = '0;
    always @(posedge clk_sys) begin
        p_v    <= {p_v[2:0], d4_fx_rd};
        p_d[0] <= d4_fx_raddr[7:0] ^ 8'h1C;
        for (int i = 1; i < 4; i++) p_d[i] <= p_d[i-1];
    end
    assign d4_fx_q = p_v[3] ? p_d[3] : 8'hEE;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_ev(input int c, input int k, input logic [31:0] v);
        ev_t e;
        int  i = 0;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        while (i < sb.size() && (sb[i].cyc < c || (sb[i].cyc == c && sb[i].kind <= k))) i++;
        sb.insert(i, e);
    endfunction

    task automatic observe(input int kind, input logic [31:0] val);
        ev_t e;
        if (sb.size() == 0) begin
            e.cyc  = -1;
            e.kind = -1;
            e.val  = '0;
        end else begin
            e = sb.pop_front();
        end
        check($sformatf("event_k%0d", kind), {8'(kind), 24'(cyc), val}, {8'(e.kind), 24'(e.cyc), e.val});
    endtask

    // Monitor: every observable event must match the head of the scoreboard (kind, cycle, payload).
    always @(negedge clk_sys) begin
        if (m0_ovf)     observe(K_M0_OVF, 32'd0);
        if (m1_ovf)     observe(K_M1_OVF, 32'd0);
        if (fx_wr)      observe(K_FX_WR, {2'b0, fx_waddr, fx_data});
        if (fx_rd)      observe(K_FX_RD, 32'(fx_raddr));
        if (m0_qvld)    observe(K_M0_QV, 32'(m0_q));
        if (m1_qvld)    observe(K_M1_QV, 32'(m1_q));
        if (d4_fx_rd)   observe(K_D4_RD, 32'(d4_fx_raddr));
        if (d4_m0_qvld) observe(K_D4_QV, 32'(d4_m0_q));
        if (d4_fx_wr || d4_m1_qvld || d4_m0_ovf || d4_m1_ovf) observe(K_D4_OTHER, 32'd0);
        if (fx_wr || fx_rd) check("strobe_excl", 64'(fx_wr & fx_rd), 64'd0);
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [31:0] wv(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {2'b0, a, d};
    endfunction

    initial begin
        int t0;
        int first;
        repeat (3) tick();
        check("rst_busy_strobes", 64'({m0_busy, m1_busy, fx_wr, fx_rd, m0_qvld, m1_qvld, m0_ovf, m1_ovf}), 64'd0);
        check("rst_addr", 64'({fx_waddr, fx_raddr}), 64'd0);
        check("rst_data_q", 64'({fx_data, m0_q, m1_q}), 64'd0);
        rst = 1'b0;
        tick();

        // Single write from m0
        t0 = cyc;
        m0_wr = 1'b1; m0_waddr = 22'h000010; m0_data = 8'hA5;
        expect_ev(t0 + 2, K_FX_WR, wv(22'h000010, 8'hA5));
        check("wr_busy_c0", 64'(m0_busy), 64'd0);
        tick();
        m0_wr = 1'b0;
        check("wr_busy_c1", 64'(m0_busy), 64'd1);
        tick();
        check("wr_busy_c2", 64'(m0_busy), 64'd0);
        exp_last = 0;
        repeat (3) tick();

        // Single read from m1, RD_LAT=1
        t0 = cyc;
        m1_rd = 1'b1; m1_raddr = 22'h000020;
        expect_ev(t0 + 2, K_FX_RD, 32'h20);
        expect_ev(t0 + 4, K_M1_QV, 32'h3C);
        tick();
        m1_rd = 1'b0;
        exp_last = 1;
        repeat (5) tick();
        check("rd_m1_q_hold", 64'(m1_q), 64'h3C);
        check("rd_m0_q_hold", 64'(m0_q), 64'h00);

        // Contention, three rounds
        for (int r = 0; r < 3; r++) begin
            t0 = cyc;
            m0_wr = 1'b1; m0_waddr = 22'(32'h100 + r); m0_data = 8'(8'h10 + r);
            m1_wr = 1'b1; m1_waddr = 22'(32'h200 + r); m1_data = 8'(8'h20 + r);
`ifdef FX_ARB_RR_EN
            first = (exp_last == 0) ? 1 : 0;
`else
            first = 0;
`endif
            if (first == 0) begin
                expect_ev(t0 + 2, K_FX_WR, wv(m0_waddr, m0_data));
                expect_ev(t0 + 4, K_FX_WR, wv(m1_waddr, m1_data));
                exp_last = 1;
            end else begin
                expect_ev(t0 + 2, K_FX_WR, wv(m1_waddr, m1_data));
                expect_ev(t0 + 4, K_FX_WR, wv(m0_waddr, m0_data));
                exp_last = 0;
            end
            tick();
            m0_wr = 1'b0; m1_wr = 1'b0;
            repeat (4) tick();
        end

        // Overflow: second m0 write lands in the release cycle and is dropped
        t0 = cyc;
        m0_wr = 1'b1; m0_waddr = 22'h000030; m0_data = 8'h5A;
        expect_ev(t0 + 2, K_M0_OVF, 32'd0);
        expect_ev(t0 + 2, K_FX_WR, wv(22'h000030, 8'h5A));
        tick();
        m0_waddr = 22'h000031; m0_data = 8'h5B;
        tick();
        m0_wr = 1'b0;
        exp_last = 0;
        repeat (3) tick();

        // Simultaneous write and read on m1: write wins, ovf next cycle
        t0 = cyc;
        m1_wr = 1'b1; m1_waddr = 22'h000040; m1_data = 8'h77;
        m1_rd = 1'b1; m1_raddr = 22'h000041;
        expect_ev(t0 + 1, K_M1_OVF, 32'd0);
        expect_ev(t0 + 2, K_FX_WR, wv(22'h000040, 8'h77));
        tick();
        m1_wr = 1'b0; m1_rd = 1'b0;
        exp_last = 1;
        repeat (4) tick();

        // Re-issue on the cycle busy falls while the read is still in flight
        t0 = cyc;
        m0_rd = 1'b1; m0_raddr = 22'h000055;
        expect_ev(t0 + 2, K_FX_RD, 32'h55);
        expect_ev(t0 + 4, K_M0_QV, 32'h49);
        expect_ev(t0 + 6, K_FX_WR, wv(22'h000056, 8'h99));
        tick();
        m0_rd = 1'b0;
        tick();
        check("reissue_busy_low", 64'(m0_busy), 64'd0);
        m0_wr = 1'b1; m0_waddr = 22'h000056; m0_data = 8'h99;
        tick();
        m0_wr = 1'b0;
        exp_last = 0;
        repeat (6) tick();

        // Reset during WAIT on the RD_LAT=4 instance
        t0 = cyc;
        d4_m0_rd = 1'b1; d4_m0_raddr = 22'h00002A;
        expect_ev(t0 + 2, K_D4_RD, 32'h2A);
        tick();
        d4_m0_rd = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("d4_rst_strobes", 64'({d4_m0_busy, d4_m1_busy, d4_fx_wr, d4_fx_rd,
                                     d4_m0_qvld, d4_m1_qvld, d4_m0_ovf, d4_m1_ovf}), 64'd0);
        check("d4_rst_addr", 64'({d4_fx_waddr, d4_fx_raddr}), 64'd0);
        check("d4_rst_data_q", 64'({d4_fx_data, d4_m0_q, d4_m1_q}), 64'd0);
        repeat (4) tick();

        t0 = cyc;
        d4_m0_rd = 1'b1; d4_m0_raddr = 22'h000033;
        expect_ev(t0 + 2, K_D4_RD, 32'h33);
        expect_ev(t0 + 7, K_D4_QV, 32'h2F);
        tick();
        d4_m0_rd = 1'b0;
        repeat (10) tick();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
